// File: rtl/cpu_pkg.sv
// Shared encodings for the DRFA core: opcodes, ALU ops, flag bits, sequencer states.
// The STEP_WAIT state exists only when CTRL_STEP_EN is defined.
package cpu_pkg;

    localparam int INSTR_WIDTH = 16;

    localparam logic [4:0] OP_MOV  = 5'b01000;
    localparam logic [4:0] OP_LDI  = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b01010;
    localparam logic [4:0] OP_JZ   = 5'b01011;
    localparam logic [4:0] OP_JC   = 5'b01100;
    localparam logic [4:0] OP_JN   = 5'b01101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_NOT  = 3'b100;
    localparam logic [2:0] ALU_COMP = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;
    localparam logic [2:0] ALU_SHL  = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_IMM = 2'd1;
    localparam logic [1:0] WSEL_RB  = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITEBACK,
        S_HALT
`ifdef CTRL_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MOV,
        CLS_LDI,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [1:0] {
        COND_ALWAYS,
        COND_Z,
        COND_C,
        COND_N
    } jump_cond_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational split of the instruction register into class, ALU op,
// register fields and immediate.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] ir,
    output instr_class_t           cls,
    output jump_cond_t             cond,
    output logic [2:0]             alu_op,
    output logic [2:0]             rd,
    output logic [2:0]             rs,
    output logic [7:0]             imm8,
    output logic                   is_illegal
);

    logic [4:0] opcode;

    assign opcode     = ir[15:11];
    assign rd         = ir[10:8];
    assign rs         = ir[7:5];
    assign imm8       = ir[7:0];
    assign alu_op     = opcode[2:0];
    assign is_illegal = (cls == CLS_ILLEGAL);

    // The eight ALU opcodes occupy 00000-00111, so only the top two bits matter there.
    always_comb begin
        cls  = CLS_ILLEGAL;
        cond = COND_ALWAYS;
        if (opcode[4:3] == 2'b00) begin
            cls = CLS_ALU;
        end else begin
            case (opcode)
                OP_MOV:  cls = CLS_MOV;
                OP_LDI:  cls = CLS_LDI;
                OP_JMP:  cls = CLS_JUMP;
                OP_JZ:   begin cls = CLS_JUMP; cond = COND_Z; end
                OP_JC:   begin cls = CLS_JUMP; cond = COND_C; end
                OP_JN:   begin cls = CLS_JUMP; cond = COND_N; end
                OP_HALT: cls = CLS_HALT;
                default: cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the DRFA core.
// Defining CTRL_STEP_EN adds a 'step' input that gates each instruction.
module control_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   instr_req,
    output logic [PC_WIDTH-1:0]    instr_addr,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic [2:0]             rf_ra_addr,
    output logic [2:0]             rf_rb_addr,
    output logic                   rf_we,
    output logic [2:0]             rf_wa_addr,
    output logic [1:0]             rf_wsel,
    output logic [7:0]             imm,
    output logic [2:0]             alu_op,
    input  logic [3:0]             alu_flags,
    output logic [3:0]             flags_q,
    output logic [PC_WIDTH-1:0]    pc,
`ifdef CTRL_STEP_EN
    input  logic                   step,
`endif
    output logic                   halted,
    output logic                   illegal
);

`ifdef CTRL_STEP_EN
    localparam state_t RETIRE_STATE = S_STEP_WAIT;
`else
    localparam state_t RETIRE_STATE = S_FETCH;
`endif

    state_t                 state, next_state;
    logic [INSTR_WIDTH-1:0] ir;
    instr_class_t           cls;
    jump_cond_t             cond;
    logic [2:0]             dec_alu_op, rd, rs;
    logic [7:0]             imm8;
    logic                   is_illegal;
    logic                   take_jump;
    logic [PC_WIDTH-1:0]    pc_inc;

    instr_decoder u_decoder (
        .ir         (ir),
        .cls        (cls),
        .cond       (cond),
        .alu_op     (dec_alu_op),
        .rd         (rd),
        .rs         (rs),
        .imm8       (imm8),
        .is_illegal (is_illegal)
    );

    assign pc_inc     = pc + PC_WIDTH'(1);
    assign instr_addr = pc;

    // Conditional jumps look only at committed flags, never the live ALU flags.
    always_comb begin
        take_jump = 1'b0;
        if (cls == CLS_JUMP) begin
            case (cond)
                COND_ALWAYS: take_jump = 1'b1;
                COND_Z:      take_jump = flags_q[FLAG_Z];
                COND_C:      take_jump = flags_q[FLAG_C];
                COND_N:      take_jump = flags_q[FLAG_N];
                default:     take_jump = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     if (instr_valid) next_state = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_ALU:     next_state = S_EXEC;
                    CLS_HALT:    next_state = S_HALT;
                    CLS_ILLEGAL: next_state = RETIRE_STATE;
                    default:     next_state = S_WRITEBACK;
                endcase
            end
            S_EXEC:      next_state = S_WRITEBACK;
            S_WRITEBACK: next_state = RETIRE_STATE;
            S_HALT:      next_state = S_HALT;
`ifdef CTRL_STEP_EN
            S_STEP_WAIT: if (step) next_state = S_FETCH;
`endif
            default:     next_state = S_FETCH;
        endcase
    end

    // Results and flags commit in WRITEBACK, one cycle after the ALU captured its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            pc      <= RESET_PC;
            flags_q <= '0;
        end else begin
            if (state == S_FETCH && instr_valid) begin
                ir <= instr_data;
            end
            if (state == S_DECODE && is_illegal) begin
                pc <= pc_inc;
            end
            if (state == S_WRITEBACK) begin
                pc <= take_jump ? PC_WIDTH'(imm8) : pc_inc;
                if (cls == CLS_ALU) begin
                    flags_q <= alu_flags;
                end
            end
        end
    end

    always_comb begin
        instr_req  = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        rf_we      = 1'b0;
        rf_wa_addr = '0;
        rf_wsel    = WSEL_ALU;
        imm        = '0;
        alu_op     = ALU_ADD;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH:  instr_req = rst_n;
            S_DECODE: begin
                rf_ra_addr = rd;
                rf_rb_addr = rs;
                imm        = imm8;
                illegal    = is_illegal;
            end
            S_EXEC: begin
                rf_ra_addr = rd;
                rf_rb_addr = rs;
                imm        = imm8;
                alu_op     = dec_alu_op;
            end
            S_WRITEBACK: begin
                rf_ra_addr = rd;
                rf_rb_addr = rs;
                imm        = imm8;
                rf_wa_addr = rd;
                case (cls)
                    CLS_ALU: begin
                        alu_op = dec_alu_op;
                        rf_we  = (dec_alu_op != ALU_COMP);
                    end
                    CLS_MOV: begin
                        rf_we   = 1'b1;
                        rf_wsel = WSEL_RB;
                    end
                    CLS_LDI: begin
                        rf_we   = 1'b1;
                        rf_wsel = WSEL_IMM;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            S_HALT:   halted = 1'b1;
            default:  instr_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with hand-computed expectations.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [2:0]  rf_ra_addr, rf_rb_addr, rf_wa_addr, alu_op;
    logic        rf_we, halted, illegal;
    logic [1:0]  rf_wsel;
    logic [7:0]  imm, pc;
    logic [3:0]  alu_flags, flags_q;
`ifdef CTRL_STEP_EN
    logic        step;
`endif

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .rf_ra_addr  (rf_ra_addr),
        .rf_rb_addr  (rf_rb_addr),
        .rf_we       (rf_we),
        .rf_wa_addr  (rf_wa_addr),
        .rf_wsel     (rf_wsel),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_flags   (alu_flags),
        .flags_q     (flags_q),
        .pc          (pc),
`ifdef CTRL_STEP_EN
        .step        (step),
`endif
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a fetch request, hands over one word, and leaves the DUT in DECODE.
    task automatic applyStimulus(input logic [15:0] word);
        for (int i = 0; i < 20 && !instr_req; i++) cycle();
        if (!instr_req) checkOutput("fetch_timeout", 32'(instr_req), 32'd1);
        instr_valid = 1'b1;
        instr_data  = word;
        cycle();
        instr_valid = 1'b0;
        instr_data  = 16'h0000;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 16'h0000;
        alu_flags   = 4'b0000;
`ifdef CTRL_STEP_EN
        step        = 1'b1;
`endif
        #12;
        checkOutput("reset_pc", 32'(pc), 32'h00);
        checkOutput("reset_addr", 32'(instr_addr), 32'h00);
        checkOutput("reset_req", 32'(instr_req), 32'd0);
        checkOutput("reset_flags", 32'(flags_q), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("req_after_release", 32'(instr_req), 32'd1);

        // add r0,r1
        alu_flags = 4'b0000;
        applyStimulus(16'h0020);
        checkOutput("add_ra", 32'(rf_ra_addr), 32'd0);
        checkOutput("add_rb", 32'(rf_rb_addr), 32'd1);
        checkOutput("add_dec_we", 32'(rf_we), 32'd0);
        cycle();
        checkOutput("add_exec_op", 32'(alu_op), 32'd0);
        checkOutput("add_exec_we", 32'(rf_we), 32'd0);
        cycle();
        checkOutput("add_wb_we", 32'(rf_we), 32'd1);
        checkOutput("add_wb_wa", 32'(rf_wa_addr), 32'd0);
        checkOutput("add_wb_wsel", 32'(rf_wsel), 32'd0);
        cycle();
        checkOutput("add_pc", 32'(pc), 32'h01);
        checkOutput("add_flags", 32'(flags_q), 32'd0);
        checkOutput("add_we_after", 32'(rf_we), 32'd0);

        // sub r2,r3
        alu_flags = 4'b0110;
        applyStimulus(16'h0A60);
        checkOutput("sub_ra", 32'(rf_ra_addr), 32'd2);
        checkOutput("sub_rb", 32'(rf_rb_addr), 32'd3);
        cycle();
        checkOutput("sub_exec_op", 32'(alu_op), 32'd1);
        cycle();
        checkOutput("sub_wb_we", 32'(rf_we), 32'd1);
        checkOutput("sub_wb_wa", 32'(rf_wa_addr), 32'd2);
        cycle();
        checkOutput("sub_flags", 32'(flags_q), 32'h6);
        checkOutput("sub_pc", 32'(pc), 32'h02);
        checkOutput("sub_op_idle", 32'(alu_op), 32'd0);

        // comp r2,r3
        alu_flags = 4'b0001;
        applyStimulus(16'h2A60);
        cycle();
        checkOutput("comp_exec_op", 32'(alu_op), 32'd5);
        cycle();
        checkOutput("comp_wb_we", 32'(rf_we), 32'd0);
        cycle();
        checkOutput("comp_flags", 32'(flags_q), 32'h1);
        checkOutput("comp_pc", 32'(pc), 32'h03);
        alu_flags = 4'b1110;

        // jz 0x40, Z=1 -> taken
        applyStimulus(16'h5840);
        cycle();
        checkOutput("jz_wb_we", 32'(rf_we), 32'd0);
        checkOutput("jz_wb_op", 32'(alu_op), 32'd0);
        cycle();
        checkOutput("jz_pc", 32'(pc), 32'h40);

        // jc 0x40, C=0 -> not taken
        applyStimulus(16'h6040);
        cycle();
        cycle();
        checkOutput("jc_pc", 32'(pc), 32'h41);

        // mov r5 <= r6
        applyStimulus(16'h45C0);
        cycle();
        checkOutput("mov_we", 32'(rf_we), 32'd1);
        checkOutput("mov_wsel", 32'(rf_wsel), 32'd2);
        checkOutput("mov_wa", 32'(rf_wa_addr), 32'd5);
        checkOutput("mov_rb", 32'(rf_rb_addr), 32'd6);
        cycle();
        checkOutput("mov_pc", 32'(pc), 32'h42);
        checkOutput("mov_flags", 32'(flags_q), 32'h1);

        // ldi r7 <= 0xA5
        applyStimulus(16'h4FA5);
        cycle();
        checkOutput("ldi_we", 32'(rf_we), 32'd1);
        checkOutput("ldi_wsel", 32'(rf_wsel), 32'd1);
        checkOutput("ldi_wa", 32'(rf_wa_addr), 32'd7);
        checkOutput("ldi_imm", 32'(imm), 32'hA5);
        cycle();
        checkOutput("ldi_pc", 32'(pc), 32'h43);

        // jmp 0xFF, then jmp from 0xFF to 0x10
        applyStimulus(16'h50FF);
        cycle();
        cycle();
        checkOutput("jmp_ff_pc", 32'(pc), 32'hFF);
        checkOutput("jmp_ff_addr", 32'(instr_addr), 32'hFF);
        applyStimulus(16'h5010);
        cycle();
        cycle();
        checkOutput("jmp_10_pc", 32'(pc), 32'h10);

        // non-jump at 0xFF wraps to 0x00
        applyStimulus(16'h50FF);
        cycle();
        cycle();
        applyStimulus(16'h4800);
        cycle();
        cycle();
        checkOutput("wrap_pc", 32'(pc), 32'h00);

        // fetch stall
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput("stall_req", 32'(instr_req), 32'd1);
            checkOutput("stall_we", 32'(rf_we), 32'd0);
            checkOutput("stall_pc", 32'(pc), 32'h00);
        end

        // illegal opcode
        applyStimulus(16'h7000);
        checkOutput("ill_pulse", 32'(illegal), 32'd1);
        checkOutput("ill_we", 32'(rf_we), 32'd0);
        cycle();
        checkOutput("ill_pulse_end", 32'(illegal), 32'd0);
        checkOutput("ill_pc", 32'(pc), 32'h01);

        // async reset mid-EXEC of sub
        alu_flags = 4'b0000;
        applyStimulus(16'h0A60);
        cycle();
        checkOutput("rst_exec_op", 32'(alu_op), 32'd1);
        checkOutput("rst_pre_flags", 32'(flags_q), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_pc", 32'(pc), 32'h00);
        checkOutput("rst_async_flags", 32'(flags_q), 32'h0);
        checkOutput("rst_async_we", 32'(rf_we), 32'd0);
        checkOutput("rst_async_op", 32'(alu_op), 32'd0);
        checkOutput("rst_async_req", 32'(instr_req), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release_req", 32'(instr_req), 32'd1);
        checkOutput("rst_release_addr", 32'(instr_addr), 32'h00);

        // halt
        applyStimulus(16'hF800);
        cycle();
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("halt_halted", 32'(halted), 32'd1);
            checkOutput("halt_req", 32'(instr_req), 32'd0);
            checkOutput("halt_pc", 32'(pc), 32'h00);
            cycle();
        end
        instr_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit DRFA core.
- Sits directly upstream of the ALU:
  - drives its op code;
  - steers register-file reads onto in_A/in_B;
  - consumes ALU flags;
  - commits ALU results and flags one cycle after execute, matching the ALU's registered output.
- Fetches 16-bit instructions through a valid/ready-style request to instruction memory.

Parameters:
- PC_WIDTH, 8, program counter width.
- RESET_PC, 8'h00, PC value loaded on reset.
- INSTR_WIDTH, 16, instruction word width; fixed by the ISA, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_req  out  1  fetch request, held until instr_valid.
- instr_addr  out  PC_WIDTH  fetch address, equals pc.
- instr_valid  in  1  instr_data valid this cycle.
- instr_data  in  16  instruction word.
- rf_ra_addr  out  3  register read port A, feeds ALU in_A (rd field).
- rf_rb_addr  out  3  register read port B, feeds ALU in_B (rs field).
- rf_we  out  1  register write enable.
- rf_wa_addr  out  3  write address.
- rf_wsel  out  2  write source: 0 ALU out, 1 imm8, 2 read port B.
- imm  out  8  immediate field.
- alu_op  out  3  ALU op: add 000, sub 001, or 010, and 011, not 100, comp 101, shr 110, shl 111.
- alu_flags  in  4  ALU flags: [0] Z, [1] N, [2] C, [3] V.
- flags_q  out  4  architectural flags register.
- pc  out  PC_WIDTH  program counter.
- halted  out  1  high in HALT state.
- illegal  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Format: [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] imm8 (overlaps rs for immediate/jump forms).
- Opcodes:
  - 00000-00111: ALU rd <= rd op rs; alu_op = opcode[2:0].
  - 01000: MOV rd <= rs.
  - 01001: LDI rd <= imm8.
  - 01010: JMP.
  - 01011: JZ.
  - 01100: JC.
  - 01101: JN.
  - 11111: HALT.
  - All others: illegal.
- Reset (async, any state, mid-instruction included): state FETCH, pc=RESET_PC, flags_q=0; all outputs 0 except instr_addr=RESET_PC. No pending write survives reset.
- States and transitions:
  - FETCH: instr_req=1. On instr_valid, latch instr_data into IR and go to DECODE; otherwise stay (unbounded wait).
  - DECODE: one cycle; drive rf_ra_addr/rf_rb_addr from IR.
    - ALU op -> EXEC.
    - MOV/LDI/jump -> WRITEBACK.
    - HALT -> HALT.
    - Illegal -> pulse illegal, pc+=1, FETCH.
  - EXEC: alu_op valid, operands presented; the ALU registers at this edge. Go to WRITEBACK.
  - WRITEBACK:
    - ALU ops: flags_q<=alu_flags; rf_we=1 with rf_wsel=0, except comp (101), which updates flags only with rf_we=0.
    - MOV: rf_wsel=2, flags unchanged.
    - LDI: rf_wsel=1, flags unchanged.
    - Jumps: taken if JMP, or if the selected flag in flags_q is 1; taken -> pc<=imm8, else pc<=pc+1.
    - Non-jumps: pc<=pc+1. Then FETCH.
  - HALT: halted=1, no requests; exit only via reset.
- Outputs: alu_op=0 outside EXEC/WRITEBACK. rf_we is high only in WRITEBACK.
- PC wraps 8'hFF -> 8'h00 with no flag or error.
- Conditional jumps read flags_q from the previous flag-writing instruction, never alu_flags.
- Latencies (no memory wait): ALU instruction 4 cycles, MOV/LDI/jump 3, illegal 2.

Optional Feature:
- Macro CTRL_STEP_EN.
- Defined: adds input step (1 bit) and state STEP_WAIT. After every retired instruction (WRITEBACK exit or illegal), wait in STEP_WAIT until step=1, then FETCH. A step held high advances one instruction per pass. Reset returns to FETCH, not STEP_WAIT.
- Undefined: no port, no state; free-running.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams;
  - ALU op codes (shared with alu);
  - flag bit indices;
  - state encoding;
  - rf_wsel encodings.
- One natural sub-module: instr_decoder, combinational, IR -> class, alu_op, rd, rs, imm8, is_illegal.

Test Plan:
- Reset: rst_n low mid-EXEC -> pc=0, flags_q=0, rf_we=0 immediately, asynchronously; first instr_req after release.
- ALU add: IR 16'h0020 (add r0,r1), ALU flags 4'b0000 -> alu_op=000 in EXEC; next cycle rf_we=1, rf_wa_addr=0, rf_wsel=0, flags_q=0, pc 0->1.
- Comp: IR 16'b00101_010_011_00000 with alu_flags 4'b0001 -> rf_we stays 0; flags_q=4'b0001.
- Jumps, with flags_q Z=1:
  - JZ 8'h40 -> pc=8'h40.
  - JC 8'h40 with C=0 -> pc increments.
  - JMP at pc 8'hFF to 8'h10 -> pc=8'h10.
  - Non-jump at 8'hFF -> pc wraps to 8'h00.
- Fetch stall: instr_valid withheld 5 cycles -> instr_req held, state FETCH, no writes.
- HALT (16'hF800) -> halted=1, instr_req=0 forever. Illegal 16'h7000 -> one-cycle illegal pulse, pc+1, no writes.
